// File: rtl/ftb_update_ctrl_pkg.sv
// Shared frontend types and helpers for the FTB update path: entry/update
// structs, engine state encoding, index/tag extraction and counter update.
package ftb_update_ctrl_pkg;

  localparam int unsigned VADDR_W       = 39;
  localparam int unsigned FTB_TAG_WIDTH = 16;

  localparam logic [1:0] FTB_CNT_INIT_T  = 2'b10;
  localparam logic [1:0] FTB_CNT_INIT_NT = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CMP,
    WR
  } ftbUpdState_t;

  typedef struct packed {
    logic [3:0]  br_off;
    logic [1:0]  br_type;
    logic [19:0] tgt;
  } ftbInfo_t;

  typedef struct packed {
    logic                     vld;
    logic [FTB_TAG_WIDTH-1:0] tag;
    logic [1:0]               cnt;
    ftbInfo_t                 info;
  } ftbEntry_t;

  typedef struct packed {
    logic [VADDR_W-1:0] startAddr;
    ftbInfo_t           ftb_update;
  } BPupdateInfo_t;

  // Result is full address width; callers narrow it to their own index width.
  function automatic logic [VADDR_W-1:0] ftbIdx(input logic [VADDR_W-1:0] start_addr,
                                                input int unsigned idx_w);
    logic [VADDR_W-1:0] mask;
    mask = (VADDR_W'(1) << idx_w) - VADDR_W'(1);
    return (start_addr >> 1) & mask;
  endfunction

  function automatic logic [FTB_TAG_WIDTH-1:0] ftbTag(input logic [VADDR_W-1:0] start_addr,
                                                      input int unsigned idx_w);
    return FTB_TAG_WIDTH'(start_addr >> (idx_w + 1));
  endfunction

  function automatic logic [1:0] ftbCntUpd(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/ftb_update_ctrl_if.sv
// Update-request and prediction-lookup handshake bundle for ftb_update_ctrl.
interface ftb_update_ctrl_if #(
  parameter int unsigned IDX_W = 9
);
  import ftb_update_ctrl_pkg::*;

  logic             upd_vld;
  logic             upd_rdy;
  BPupdateInfo_t    upd_info;
  logic             upd_taken;
  logic             lkp_vld;
  logic [IDX_W-1:0] lkp_idx;
  logic             lkp_stall;

  modport master (
    output upd_vld, upd_info, upd_taken, lkp_vld, lkp_idx,
    input  upd_rdy, lkp_stall
  );

  modport slave (
    input  upd_vld, upd_info, upd_taken, lkp_vld, lkp_idx,
    output upd_rdy, lkp_stall
  );

endinterface

// File: rtl/ftb_upd_fifo.sv
// Parametric synchronous FIFO with full/empty flags; storage is not reset.
module ftb_upd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ftb_update_ctrl.sv
// Read-modify-write sequencer for FTB updates sharing the single SRAM port with
// lookups. Optional FTB_UPD_PERF_EN adds hit/miss/stall performance counters.
module ftb_update_ctrl
  import ftb_update_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W      = 9,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic             clk,
  input  logic             rst,
  ftb_update_ctrl_if.slave bus,
  output logic             sram_en,
  output logic             sram_we,
  output logic [IDX_W-1:0] sram_idx,
  output ftbEntry_t        sram_wdata,
  input  ftbEntry_t        sram_rdata
`ifdef FTB_UPD_PERF_EN
  ,
  output logic [31:0]      perf_hit_cnt,
  output logic [31:0]      perf_miss_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int unsigned SC_W = $clog2(STARVE_LIM + 1);
  localparam int unsigned QW   = $bits(BPupdateInfo_t) + 1;

  ftbUpdState_t     state, state_nxt;
  logic [SC_W-1:0]  starve_cnt;
  BPupdateInfo_t    work_info;
  logic             work_taken;
  ftbEntry_t        work_entry;
  logic [IDX_W-1:0] work_idx;

  logic [QW-1:0]    q_head;
  logic             q_full, q_empty, q_pop;
  logic             eng_req, eng_win, lkp_win;

  function automatic ftbEntry_t new_entry(input ftbEntry_t old, input BPupdateInfo_t upd,
                                          input logic taken);
    ftbEntry_t                e;
    logic [FTB_TAG_WIDTH-1:0] tag;
    tag    = ftbTag(upd.startAddr, IDX_W);
    e.vld  = 1'b1;
    e.tag  = tag;
    e.info = upd.ftb_update;
    if (old.vld && (old.tag == tag)) e.cnt = ftbCntUpd(old.cnt, taken);
    else                             e.cnt = taken ? FTB_CNT_INIT_T : FTB_CNT_INIT_NT;
    return e;
  endfunction

  ftb_upd_fifo #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.upd_vld),
    .push_data ({bus.upd_info, bus.upd_taken}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign bus.upd_rdy = ~q_full;
  assign work_idx    = IDX_W'(ftbIdx(work_info.startAddr, IDX_W));

  // Reset masks the engine request so an in-flight write is dropped in the reset cycle.
  assign eng_req       = ~rst & ((state == RD) | (state == WR));
  assign eng_win       = eng_req & (~bus.lkp_vld | (starve_cnt >= SC_W'(STARVE_LIM)));
  assign lkp_win       = bus.lkp_vld & ~eng_win;
  assign bus.lkp_stall = bus.lkp_vld & eng_win;

  assign sram_en    = eng_win | lkp_win;
  assign sram_we    = eng_win & (state == WR);
  assign sram_idx   = eng_win ? work_idx : (lkp_win ? bus.lkp_idx : '0);
  assign sram_wdata = sram_we ? work_entry : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (!q_empty) begin
            q_pop     = 1'b1;
            state_nxt = RD;
          end
        end
        RD:      if (eng_win) state_nxt = CMP;
        CMP:     state_nxt = WR;
        WR:      if (eng_win) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                               starve_cnt <= '0;
    else if (eng_win)                                      starve_cnt <= '0;
    else if (eng_req && (starve_cnt < SC_W'(STARVE_LIM)))  starve_cnt <= starve_cnt + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (q_pop)         {work_info, work_taken} <= q_head;
    if (state == CMP)  work_entry <= new_entry(sram_rdata, work_info, work_taken);
  end

`ifdef FTB_UPD_PERF_EN
  logic cmp_hit;
  assign cmp_hit = sram_rdata.vld && (sram_rdata.tag == ftbTag(work_info.startAddr, IDX_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_cnt   <= '0;
      perf_miss_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (state == CMP) begin
        if (cmp_hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
        else         perf_miss_cnt <= perf_miss_cnt + 32'd1;
      end
      if (bus.lkp_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ftb_update_ctrl.sv
// Scoreboard bench for ftb_update_ctrl: expected writes queued at enqueue, compared on SRAM writes.
module tb_ftb_update_ctrl;
  import ftb_update_ctrl_pkg::*;

  localparam int unsigned IDX_W      = 9;
  localparam int unsigned QDEPTH     = 4;
  localparam int unsigned STARVE_LIM = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sram_en, sram_we;
  logic [IDX_W-1:0] sram_idx;
  ftbEntry_t        sram_wdata, sram_rdata;
`ifdef FTB_UPD_PERF_EN
  logic [31:0]      perf_hit_cnt, perf_miss_cnt, perf_stall_cnt;
`endif

  ftb_update_ctrl_if #(.IDX_W(IDX_W)) bus ();

  ftb_update_ctrl #(
    .IDX_W      (IDX_W),
    .QDEPTH     (QDEPTH),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_idx   (sram_idx),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
`ifdef FTB_UPD_PERF_EN
    ,
    .perf_hit_cnt   (perf_hit_cnt),
    .perf_miss_cnt  (perf_miss_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    ftbEntry_t        e;
    int               cyc;
  } wr_t;

  ftbEntry_t        mem    [1 << IDX_W];
  ftbEntry_t        shadow [1 << IDX_W];
  logic             pre_we = 1'b0;
  logic [IDX_W-1:0] pre_idx;
  ftbEntry_t        pre_e;
  int               cyc = 0;
  wr_t              obs_q [$];
  wr_t              exp_q [$];
  int               stall_q [$];
  int               obs_rd = 0;
  int               stall_rd = 0;
  int               compared = 0;
  int               mismatched = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_en && !sram_we) sram_rdata <= mem[sram_idx];
    if (sram_en && sram_we)  mem[sram_idx] <= sram_wdata;
    if (pre_we)              mem[pre_idx] <= pre_e;
  end

  always @(negedge clk) begin
    if (sram_en === 1'b1 && sram_we === 1'b1) obs_q.push_back('{sram_idx, sram_wdata, cyc});
    if (bus.lkp_stall === 1'b1) stall_q.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [VADDR_W-1:0] mk_addr(input logic [IDX_W-1:0] idx,
                                                 input logic [FTB_TAG_WIDTH-1:0] tag);
    logic [VADDR_W-1:0] a;
    a = '0;
    a[0] = 1'b1;
    a[VADDR_W-1] = 1'b1;
    a[IDX_W:1] = idx;
    a[IDX_W+1 +: FTB_TAG_WIDTH] = tag;
    return a;
  endfunction

  function automatic ftbInfo_t rnd_info();
    logic [31:0] r;
    r = $urandom;
    return r[$bits(ftbInfo_t)-1:0];
  endfunction

  function automatic ftbEntry_t model(input ftbEntry_t old, input logic [VADDR_W-1:0] a,
                                     input logic t, input ftbInfo_t inf);
    ftbEntry_t                e;
    logic [FTB_TAG_WIDTH-1:0] tg;
    tg     = a[IDX_W+1 +: FTB_TAG_WIDTH];
    e.vld  = 1'b1;
    e.tag  = tg;
    e.info = inf;
    if (old.vld === 1'b1 && old.tag === tg) begin
      case ({t, old.cnt})
        3'b1_11: e.cnt = 2'b11;
        3'b0_00: e.cnt = 2'b00;
        default: e.cnt = t ? old.cnt + 2'b01 : old.cnt - 2'b01;
      endcase
    end else begin
      e.cnt = t ? 2'b10 : 2'b01;
    end
    return e;
  endfunction

  task automatic preload(input logic [IDX_W-1:0] idx, input ftbEntry_t e);
    pre_we = 1'b1;
    pre_idx = idx;
    pre_e = e;
    shadow[idx] = e;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic enq(input logic [VADDR_W-1:0] addr, input logic taken, input ftbInfo_t inf,
                     input bit track, output int acc);
    wr_t w;
    acc = -1;
    bus.upd_vld   = 1'b1;
    bus.upd_info  = '{addr, inf};
    bus.upd_taken = taken;
    if (track) begin
      w.idx = addr[IDX_W:1];
      w.e   = model(shadow[w.idx], addr, taken, inf);
      w.cyc = 0;
      shadow[w.idx] = w.e;
      exp_q.push_back(w);
    end
    for (int n = 0; n < 200 && acc < 0; n++) begin
      @(negedge clk);
      if (bus.upd_rdy === 1'b1) acc = cyc;
      @(posedge clk); #1;
    end
    bus.upd_vld = 1'b0;
    if (acc < 0) begin
      compared++; mismatched++;
      $display("FAIL enq_timeout: upd_rdy never 1, required 1 within 200 cycles");
    end
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && (obs_q.size() - obs_rd) < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      bus.lkp_vld = ((i % 2) == 1);
      bus.lkp_idx = IDX_W'(i * 37 + 5);
      @(negedge clk);
      compared++;
      if (sram_en !== bus.lkp_vld || sram_we !== 1'b0 || bus.lkp_stall !== 1'b0 ||
          (bus.lkp_vld && sram_idx !== bus.lkp_idx)) begin
        mismatched++;
        $display("FAIL reset_outputs: en=%b we=%b stall=%b idx=%0h, required en=%b we=0 stall=0 idx=%0h",
                 sram_en, sram_we, bus.lkp_stall, sram_idx, bus.lkp_vld, bus.lkp_idx);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.lkp_vld = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.upd_rdy !== 1'b1 || sram_en !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset: upd_rdy=%b sram_en=%b, required upd_rdy=1 sram_en=0", bus.upd_rdy, sram_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hit_taken();
    logic [VADDR_W-1:0] a;
    int  acc;
    wr_t e, o;
    a = mk_addr(9'h012, 16'hBEEF);
    preload(9'h012, '{vld:1'b1, tag:16'hBEEF, cnt:2'b01, info:rnd_info()});
    enq(a, 1'b1, rnd_info(), 1'b1, acc);
    wait_writes(1, 50);
    e = exp_q.pop_front();
    compared++;
    if (obs_rd >= obs_q.size()) begin
      mismatched++;
      $display("FAIL hit_taken: no write seen, required idx %0h entry %h", e.idx, e.e);
    end else begin
      o = obs_q[obs_rd]; obs_rd++;
      if (o.idx !== e.idx || o.e !== e.e) begin
        mismatched++;
        $display("FAIL hit_taken: idx %0h entry %h, required idx %0h entry %h", o.idx, o.e, e.idx, e.e);
      end
      compared++;
      if (o.cyc - acc !== 4) begin
        mismatched++;
        $display("FAIL hit_latency: %0d cycles, required 4", o.cyc - acc);
      end
      compared++;
      if (o.e.cnt !== 2'b10) begin
        mismatched++;
        $display("FAIL hit_cnt: cnt %b, required 10", o.e.cnt);
      end
    end
  endtask

  task automatic test_miss();
    int  acc;
    wr_t e, o;
    preload(9'h030, '{vld:1'b0, tag:16'h1234, cnt:2'b11, info:rnd_info()});
    preload(9'h031, '{vld:1'b1, tag:16'h5555, cnt:2'b00, info:rnd_info()});
    enq(mk_addr(9'h030, 16'h1234), 1'b0, rnd_info(), 1'b1, acc);
    enq(mk_addr(9'h031, 16'hAAAA), 1'b1, rnd_info(), 1'b1, acc);
    wait_writes(exp_q.size(), 80);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_rd >= obs_q.size()) begin
        mismatched++;
        $display("FAIL miss: no write seen, required idx %0h entry %h", e.idx, e.e);
      end else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o.idx !== e.idx || o.e !== e.e) begin
          mismatched++;
          $display("FAIL miss: idx %0h entry %h, required idx %0h entry %h", o.idx, o.e, e.idx, e.e);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int  acc;
    wr_t e, o;
    preload(9'h050, '{vld:1'b1, tag:16'h0F0F, cnt:2'b11, info:rnd_info()});
    preload(9'h051, '{vld:1'b1, tag:16'h0F0F, cnt:2'b00, info:rnd_info()});
    preload(9'h052, '{vld:1'b1, tag:16'h0F0F, cnt:2'b10, info:rnd_info()});
    enq(mk_addr(9'h050, 16'h0F0F), 1'b1, rnd_info(), 1'b1, acc);
    enq(mk_addr(9'h051, 16'h0F0F), 1'b0, rnd_info(), 1'b1, acc);
    enq(mk_addr(9'h052, 16'h0F0F), 1'b0, rnd_info(), 1'b1, acc);
    wait_writes(exp_q.size(), 100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_rd >= obs_q.size()) begin
        mismatched++;
        $display("FAIL saturation: no write seen, required idx %0h entry %h", e.idx, e.e);
      end else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o.idx !== e.idx || o.e !== e.e) begin
          mismatched++;
          $display("FAIL saturation: idx %0h cnt %b entry %h, required idx %0h cnt %b entry %h",
                   o.idx, o.e.cnt, o.e, e.idx, e.e.cnt, e.e);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int  acc;
    wr_t e, o;
    preload(9'h070, '{vld:1'b1, tag:16'h7777, cnt:2'b01, info:rnd_info()});
    stall_rd = stall_q.size();
    bus.lkp_vld = 1'b1;
    bus.lkp_idx = 9'h1AA;
    enq(mk_addr(9'h070, 16'h7777), 1'b1, rnd_info(), 1'b1, acc);
    @(posedge clk); @(posedge clk); @(negedge clk);
    compared++;
    if (sram_en !== 1'b1 || sram_we !== 1'b0 || sram_idx !== 9'h1AA || bus.lkp_stall !== 1'b0) begin
      mismatched++;
      $display("FAIL lookup_grant: en=%b we=%b idx=%0h stall=%b, required en=1 we=0 idx=1aa stall=0",
               sram_en, sram_we, sram_idx, bus.lkp_stall);
    end
    wait_writes(1, 60);
    @(posedge clk); #1;
    bus.lkp_vld = 1'b0;
    e = exp_q.pop_front();
    compared++;
    if (obs_rd >= obs_q.size()) begin
      mismatched++;
      $display("FAIL starve_write: no write seen, required idx %0h entry %h", e.idx, e.e);
    end else begin
      o = obs_q[obs_rd]; obs_rd++;
      if (o.idx !== e.idx || o.e !== e.e || o.cyc - acc !== 10) begin
        mismatched++;
        $display("FAIL starve_write: idx %0h entry %h at +%0d, required idx %0h entry %h at +10",
                 o.idx, o.e, o.cyc - acc, e.idx, e.e);
      end
    end
    compared++;
    if (stall_q.size() - stall_rd !== 2) begin
      mismatched++;
      $display("FAIL starve_stall_count: %0d stall cycles, required 2", stall_q.size() - stall_rd);
    end else begin
      compared++;
      if (stall_q[stall_rd] - acc !== 5 || stall_q[stall_rd+1] - acc !== 10) begin
        mismatched++;
        $display("FAIL starve_stall_cycles: +%0d,+%0d, required +5,+10",
                 stall_q[stall_rd] - acc, stall_q[stall_rd+1] - acc);
      end
    end
    stall_rd = stall_q.size();
  endtask

  task automatic test_back_to_back();
    int  acc_a;
    int  acc [5];
    int  first_cyc;
    wr_t e, o;
    preload(9'h060, '{vld:1'b1, tag:16'h6060, cnt:2'b10, info:rnd_info()});
    for (int k = 0; k < 4; k++)
      preload(IDX_W'(9'h040 + k), '{vld:1'b1, tag:16'h4040, cnt:2'b01, info:rnd_info()});
    bus.lkp_vld = 1'b1;
    bus.lkp_idx = 9'h003;
    enq(mk_addr(9'h060, 16'h6060), 1'b0, rnd_info(), 1'b1, acc_a);
    for (int k = 0; k < 4; k++)
      enq(mk_addr(IDX_W'(9'h040 + k), 16'h4040), 1'b1, rnd_info(), 1'b1, acc[k]);
    @(negedge clk);
    compared++;
    if (bus.upd_rdy !== 1'b0) begin
      mismatched++;
      $display("FAIL queue_full: upd_rdy=%b after 4 queued, required 0", bus.upd_rdy);
    end
    enq(mk_addr(9'h040, 16'h4040), 1'b1, rnd_info(), 1'b1, acc[4]);
    bus.lkp_vld = 1'b0;
    compared++;
    if (acc[1] - acc[0] !== 1 || acc[2] - acc[0] !== 2 || acc[3] - acc[0] !== 3) begin
      mismatched++;
      $display("FAIL b2b_accept: offsets %0d %0d %0d, required 1 2 3",
               acc[1] - acc[0], acc[2] - acc[0], acc[3] - acc[0]);
    end
    first_cyc = -1;
    wait_writes(exp_q.size(), 300);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_rd >= obs_q.size()) begin
        mismatched++;
        $display("FAIL b2b_write: no write seen, required idx %0h entry %h", e.idx, e.e);
      end else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (first_cyc < 0) first_cyc = o.cyc;
        if (o.idx !== e.idx || o.e !== e.e) begin
          mismatched++;
          $display("FAIL b2b_write: idx %0h entry %h, required idx %0h entry %h", o.idx, o.e, e.idx, e.e);
        end
      end
    end
    compared++;
    if (acc[4] - first_cyc !== 2) begin
      mismatched++;
      $display("FAIL fifth_held: accepted %0d cycles after first write, required 2", acc[4] - first_cyc);
    end
    stall_rd = stall_q.size();
  endtask

  task automatic test_reset_mid_write();
    int acc, a2, a3, seen;
    bus.lkp_vld = 1'b1;
    bus.lkp_idx = 9'h0F0;
    enq(mk_addr(9'h011, 16'h1111), 1'b1, rnd_info(), 1'b0, acc);
    enq(mk_addr(9'h013, 16'h1313), 1'b1, rnd_info(), 1'b0, a2);
    enq(mk_addr(9'h014, 16'h1414), 1'b0, rnd_info(), 1'b0, a3);
    for (int n = 0; n < 50 && cyc < acc + 8; n++) begin
      @(posedge clk); #1;
    end
    seen = obs_q.size();
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (sram_we !== 1'b0 || sram_en !== 1'b1 || sram_idx !== 9'h0F0 || bus.lkp_stall !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_in_wr: en=%b we=%b idx=%0h stall=%b, required en=1 we=0 idx=0f0 stall=0",
               sram_en, sram_we, sram_idx, bus.lkp_stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.lkp_vld = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.upd_rdy !== 1'b1 || sram_en !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: upd_rdy=%b sram_en=%b, required upd_rdy=1 sram_en=0", bus.upd_rdy, sram_en);
    end
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
    end
    compared++;
    if (obs_q.size() !== seen) begin
      mismatched++;
      $display("FAIL reset_flush: %0d writes after reset, required 0", obs_q.size() - seen);
    end
  endtask

  initial begin
    bus.upd_vld   = 1'b0;
    bus.upd_info  = '0;
    bus.upd_taken = 1'b0;
    bus.lkp_vld   = 1'b0;
    bus.lkp_idx   = '0;
    test_reset();
    test_hit_taken();
    test_miss();
    test_saturation();
    test_starvation();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ftb_update_ctrl.md
Name: ftb_update_ctrl

Overview:
- Sequences branch-predictor updates into the single-port FTB SRAM using read-modify-write.
- Shares that SRAM port between prediction lookups and the update engine; lookups have priority, bounded by a starvation limit.
- Sits between the FTQ/commit update path (BPupdateInfo_t) and the FTB storage array.

Parameters:
- IDX_W, 9, FTB set index width; idx = startAddr[IDX_W:1].
- QDEPTH, 4, update queue depth (power of 2, >=2).
- STARVE_LIM, 3, consecutive lost arbitrations before the update engine wins the port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- upd_vld  in  1  update request valid
- upd_rdy  out  1  queue can accept
- upd_info  in  $bits(BPupdateInfo_t)  startAddr + new ftbInfo_t
- upd_taken  in  1  resolved direction of the update
- lkp_vld  in  1  prediction lookup request
- lkp_idx  in  IDX_W  lookup index
- lkp_stall  out  1  lookup denied this cycle
- sram_en  out  1  SRAM access enable
- sram_we  out  1  write enable
- sram_idx  out  IDX_W  SRAM index
- sram_wdata  out  $bits(ftbEntry_t)  write data
- sram_rdata  in  $bits(ftbEntry_t)  read data, valid 1 cycle after a read

Behaviour:
- Interface fixed: one clock, clk; reset rst is synchronous and active-high.
- Queue:
  - FIFO of {upd_info, upd_taken}.
  - Enqueue on upd_vld & upd_rdy; upd_rdy = !full (full-only, so no enqueue while full even if dequeuing).
- FSM states: IDLE, RD, CMP, WR.
- IDLE:
  - Queue non-empty -> latch head into working regs, pop, go RD.
- RD:
  - Request read of idx(head).
  - If granted -> CMP.
  - Else stay RD and increment starve_cnt.
- CMP:
  - Sample sram_rdata, form new entry, go WR.
  - No port request in this state.
- WR:
  - Request write.
  - If granted -> IDLE.
  - Else stay WR and increment starve_cnt.
- Arbitration, per cycle, combinational:
  - Engine wins if (engine requests & !lkp_vld) or (engine requests & starve_cnt >= STARVE_LIM).
  - Otherwise the lookup wins.
  - lkp_stall = lkp_vld & engine wins.
  - starve_cnt clears on every engine grant; it saturates and does not wrap.
- SRAM outputs:
  - Engine grant -> sram_en=1; sram_we=1 only in WR; sram_idx = working idx.
  - Lookup grant -> sram_en=1, sram_we=0, sram_idx=lkp_idx.
  - Otherwise all zero.
  - Lookup read data belongs to the requester; this block ignores it.
- Tag and hit:
  - tag = startAddr[IDX_W+1 +: FTB_TAG_WIDTH].
  - Hit = rdata.vld & rdata.tag==tag.
- New entry on hit:
  - vld=1, tag, info = upd ftb_update.
  - Counter = saturating +1 if taken, else saturating -1 (3 stays 3, 0 stays 0).
- New entry on miss:
  - vld=1, tag, info = upd ftb_update.
  - Counter = taken ? 2'b10 : 2'b01.
- Latency: min 4 cycles from enqueue into an empty queue to the write grant (enq, IDLE pop, RD, CMP, WR issue at cycle 4).
- Same-index hazard: a lookup in the same cycle as the engine write returns pre-write data; this is acceptable.
- Back-to-back updates to the same idx serialize naturally, because the second RD follows the first WR.
- Reset:
  - Empties the queue; FSM -> IDLE; starve_cnt=0.
  - A write in flight mid-operation is discarded; the next cycle issues none.
- Reset values: upd_rdy=1 the cycle after reset; sram_en=lkp_vld, sram_we=0, lkp_stall=0 during and after reset.

Optional Feature:
- Macro FTB_UPD_PERF_EN.
- Defined: 32-bit outputs perf_hit_cnt, perf_miss_cnt, perf_stall_cnt.
  - Hit/miss counters increment on CMP.
  - Stall counter increments when lkp_stall=1.
  - All wrap, reset to 0.
- Undefined: these ports and counters are absent, with no logic impact.

Decomposition:
- Shared frontend package:
  - ftbUpdState_t enum (IDLE, RD, CMP, WR).
  - Functions ftbIdx(startAddr), ftbTag(startAddr), ftbCntUpd(cnt, taken).
  - Miss init constants FTB_CNT_INIT_T=2'b10 and FTB_CNT_INIT_NT=2'b01.
- One sub-module: ftb_upd_fifo (parametric sync FIFO with full/empty).

Test Plan:
- Single update with no lookups, SRAM returns tag-hit counter 2'b01, taken=1 -> write at cycle 4, counter 2'b10, sram_we=1.
- Miss (rdata.vld=0), taken=0 -> written entry vld=1, tag = startAddr bits, counter 2'b01.
- lkp_vld held high, STARVE_LIM=3, one update queued -> engine RD granted on the 4th RD cycle; lkp_stall=1 exactly that cycle; same again in WR.
- Enqueue 5 updates back-to-back with QDEPTH=4, port busy -> upd_rdy drops after 4; the 5th is held until the first pop; all 5 eventually written in order.
- Hit with counter 2'b11 taken and 2'b00 not-taken -> counters stay 3 and 0 (saturation).
- Assert rst while in WR with a lookup present -> no write that cycle; queue empty next cycle; sram_en follows lkp_vld only.
